dmem_byte_responder: RTL
========================

Name: dmem_byte_responder

Overview:
Responder end of the core's data-memory interface. It accepts 16-bit load/store requests from the multi-cycle core's MEM stage and serves them from byte-wide storage as two little-endian byte accesses, with programmable wait states. It returns a one-cycle response pulse and replaces the core's zero-latency data memory with a handshaked, latency-bearing one.

Parameters:
DEPTH, 128, storage size in bytes; power of 2; index = address mod DEPTH.
WAIT, 1, extra wait cycles per byte access; range 0..15.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept; high only in IDLE
req_we  in  1  1 = store, 0 = load
req_addr  in  16  byte address of the low byte
req_wdata  in  16  store data; [7:0] goes to addr, [15:8] goes to addr+1
resp_valid  out  1  one-cycle completion pulse, for loads and stores
resp_rdata  out  16  load data; registered; holds until the next load completes
resp_err  out  1  misaligned-access flag; valid with resp_valid
busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset (async): state=IDLE, wait counter=0, resp_valid=0, resp_rdata=0x0000, resp_err=0, busy=0.
- Reset does not clear storage contents.
- Accept: on a rising edge with req_valid & req_ready, latch addr, we and wdata; next state is BYTE0.
- While not in IDLE, req_ready=0 and req_valid is ignored; no queueing.
- FSM states: IDLE, BYTE0, BYTE1, RESP.
  - IDLE -> BYTE0 on accept.
  - BYTE0: lasts WAIT+1 cycles, counted by the wait counter. On its last cycle's edge:
    - store: write mem[a0]=wdata[7:0];
    - load: capture the low byte.
  - BYTE1: lasts WAIT+1 cycles, with a1=(addr+1) mod DEPTH. On its last edge:
    - store: write mem[a1]=wdata[15:8];
    - load: capture the high byte.
  - RESP: exactly 1 cycle, resp_valid=1; then IDLE.
- Index width: a0 = addr mod DEPTH. Upper address bits are ignored, so addresses alias.
- Wrap-around: a1 wraps, so addr=DEPTH-1 pairs with byte 0.
- Latency: resp_valid is high in the cycle following 2*(WAIT+1) edges after the accept edge. WAIT=1 gives 4 edges.
- Minimum request spacing: 2*(WAIT+1)+2 cycles.
- resp_rdata update: loads update it on the edge entering RESP, and it is valid while resp_valid is high. Stores leave resp_rdata unchanged.
- Ordering: a store followed by a load to the same address returns the stored data.
- Reset mid-operation: the transaction is aborted and no response is issued.
  - A store whose BYTE0 write already occurred leaves that byte written and the high byte untouched.
- resp_err is 0 unless DMEM_ALIGN_CHECK_EN is defined.

Optional Feature:
DMEM_ALIGN_CHECK_EN
- Defined: an accepted request with req_addr[0]=1 skips BYTE0/BYTE1.
  - IDLE -> RESP directly; resp_valid and resp_err=1 in the cycle after the accept edge.
  - No storage access; resp_rdata unchanged.
  - resp_err returns to 0 when leaving RESP.
- Not defined: resp_err is tied to 0, and odd addresses are served as unaligned byte pairs, with wrap.

Test Plan:
1. Reset: assert rst asynchronously mid-cycle -> immediately resp_valid=0, resp_rdata=0x0000, resp_err=0, busy=0; req_ready=1 after release.
2. WAIT=1, DEPTH=128: store 0xBEEF at 0x0010, then load 0x0010 -> mem[0x10]=0xEF and mem[0x11]=0xBE; resp_valid rises exactly 4 edges after each accept; load returns resp_rdata=0xBEEF.
3. Aliasing: store 0xA55A at 0x00FE, load 0x007E -> 0xA55A. Without the macro, store 0xCAFE at 0x007F -> mem[0x7F]=0xFE, mem[0x00]=0xCA; load 0x007F returns 0xCAFE.
4. Back-pressure: hold req_valid=1 continuously with changing addresses -> req_ready=0 and inputs ignored while busy; next accept occurs in the IDLE cycle after the RESP cycle; spacing is 6 cycles for WAIT=1.
5. Reset mid-store: store 0x1234 at 0x0020 and assert rst one cycle after BYTE0's write edge -> mem[0x20]=0x34, mem[0x21] unchanged, no resp_valid pulse, state IDLE.
6. With DMEM_ALIGN_CHECK_EN: load 0x0011 -> resp_valid=1 and resp_err=1 one edge after accept, resp_rdata keeps its previous value, storage unchanged; a following aligned load gives resp_err=0.

Source files
------------

// File: rtl/dmem_byte_responder_if.sv
// Request/response bundle between the core's MEM stage (master) and the
// byte-wide data-memory responder (slave).
interface dmem_byte_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

// File: rtl/dmem_byte_responder.sv
// 16-bit load/store responder over byte-wide storage: two little-endian byte
// accesses with WAIT extra cycles each. Optional macro: DMEM_ALIGN_CHECK_EN.
module dmem_byte_responder #(
    parameter int DEPTH = 128,
    parameter int WAIT  = 1
) (
    input logic                   clk,
    input logic                   rst,
    dmem_byte_responder_if.slave  bus
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_L = 4'(WAIT);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, RESP} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [3:0]    r_wait;
    logic [3:0]    w_wait_next;

    logic [AW-1:0] r_a0;
    logic          r_we;
    logic [15:0]   r_wdata;
    logic [7:0]    r_lo;
    logic [15:0]   r_rdata;

    logic [7:0]    r_mem [DEPTH];

    logic          w_accept;
    logic          w_last;
    logic          w_misaligned;
    logic [AW-1:0] w_a1;
    logic          w_wr_en;
    logic [AW-1:0] w_wr_idx;
    logic [7:0]    w_wr_byte;
    logic          w_unused_addr;

    // Upper address bits alias onto the same storage and are deliberately dropped.
    assign w_unused_addr = ^bus.req_addr[15:AW];

    assign w_a1   = r_a0 + AW'(1);
    assign w_last = (r_wait == WAIT_L);

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = bus.req_addr[0];
`else
    assign w_misaligned = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_wait  <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_wait_next = 4'd0;
                if (bus.req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_misaligned ? RESP : BYTE0;
                end
            end
            BYTE0: begin
                if (w_last) begin
                    w_state_next = BYTE1;
                    w_wait_next  = 4'd0;
                end else begin
                    w_wait_next  = r_wait + 4'd1;
                end
            end
            BYTE1: begin
                if (w_last) begin
                    w_state_next = RESP;
                    w_wait_next  = 4'd0;
                end else begin
                    w_wait_next  = r_wait + 4'd1;
                end
            end
            RESP: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
                w_wait_next  = 4'd0;
            end
        endcase
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.busy       = (r_state != IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a0    <= '0;
            r_we    <= 1'b0;
            r_wdata <= 16'h0000;
            r_lo    <= 8'h00;
            r_rdata <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_a0    <= bus.req_addr[AW-1:0];
                r_we    <= bus.req_we;
                r_wdata <= bus.req_wdata;
            end
            if (r_state == BYTE0 && w_last && !r_we)
                r_lo <= r_mem[r_a0];
            // Loads publish the whole halfword on the edge entering RESP.
            if (r_state == BYTE1 && w_last && !r_we)
                r_rdata <= {r_mem[w_a1], r_lo};
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    logic r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= w_misaligned;
        else if (r_state == RESP)
            r_err <= 1'b0;
    end

    assign bus.resp_err = r_err;
`else
    assign bus.resp_err = 1'b0;
`endif

    assign w_wr_en   = r_we && w_last && (r_state == BYTE0 || r_state == BYTE1);
    assign w_wr_idx  = (r_state == BYTE1) ? w_a1 : r_a0;
    assign w_wr_byte = (r_state == BYTE1) ? r_wdata[15:8] : r_wdata[7:0];

    // Storage survives reset; only the control path is cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_mem[w_wr_idx] <= w_wr_byte;
    end
endmodule
